// File: rtl/udp_tx_stream_arbiter.sv
// Packet-level round-robin arbiter sharing the 400G UDP/IP AXIS TX port among N_SOURCES generators.
// Optional build macro UDP_TX_ARB_STRICT_PRIO_EN: source 0 always wins, others rotate.
module udp_tx_stream_arbiter #(
  parameter int N_SOURCES         = 4,
  parameter int G_AXIS_DATA_WIDTH = 1024,
  parameter int G_KEEP_WIDTH      = G_AXIS_DATA_WIDTH / 8
) (
  input  logic                                 axis_streaming_data_clk,
  input  logic                                 axis_streaming_rst_n,
  input  logic                                 arb_enable,
  input  logic [N_SOURCES*G_AXIS_DATA_WIDTH-1:0] src_tdata,
  input  logic [N_SOURCES-1:0]                 src_tvalid,
  input  logic [N_SOURCES*G_KEEP_WIDTH-1:0]    src_tkeep,
  input  logic [N_SOURCES-1:0]                 src_tlast,
  input  logic [N_SOURCES-1:0]                 src_tuser,
  output logic [N_SOURCES-1:0]                 src_tready,
  input  logic [N_SOURCES*32-1:0]              src_dest_ip,
  input  logic [N_SOURCES*16-1:0]              src_dest_udp_port,
  input  logic [N_SOURCES*16-1:0]              src_src_udp_port,
  input  logic [N_SOURCES*16-1:0]              src_packet_length,
  output logic [G_AXIS_DATA_WIDTH-1:0]         axis_streaming_data_tx_tdata,
  output logic                                 axis_streaming_data_tx_tvalid,
  output logic [G_KEEP_WIDTH-1:0]              axis_streaming_data_tx_tkeep,
  output logic                                 axis_streaming_data_tx_tlast,
  output logic                                 axis_streaming_data_tx_tuser,
  input  logic                                 axis_streaming_data_tx_tready,
  output logic [31:0]                          axis_streaming_data_tx_destination_ip,
  output logic [15:0]                          axis_streaming_data_tx_destination_udp_port,
  output logic [15:0]                          axis_streaming_data_tx_source_udp_port,
  output logic [15:0]                          axis_streaming_data_tx_packet_length,
  output logic [$clog2(N_SOURCES)-1:0]         grant_id,
  output logic                                 busy
);

  localparam int GW = $clog2(N_SOURCES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [GW-1:0] pick;
  logic          found;
  logic          cand;
  int            idx;
  logic          pkt_done;

  // Scan last_grant+1 .. last_grant+N with an explicit wrap so non-power-of-2 N works.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pick  = grant_id;
    found = 1'b0;
    cand  = 1'b0;
    idx   = 0;
`ifdef UDP_TX_ARB_STRICT_PRIO_EN
    if (src_tvalid[0]) begin
      pick  = '0;
      found = 1'b1;
    end
`endif
    for (int k = 1; k <= N_SOURCES; k++) begin
      idx = int'(grant_id) + k;
      if (idx >= N_SOURCES) idx = idx - N_SOURCES;
      cand = src_tvalid[idx];
`ifdef UDP_TX_ARB_STRICT_PRIO_EN
      if (idx == 0) cand = 1'b0;
`endif
      if (!found && cand) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  assign pkt_done = axis_streaming_data_tx_tvalid & axis_streaming_data_tx_tready
                  & axis_streaming_data_tx_tlast;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (arb_enable && found) state_next = S_PASS;
      S_PASS:  if (pkt_done)            state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  // NOTE: the metadata registers are reset explicitly because downstream sees them as outputs.
  always_ff @(posedge axis_streaming_data_clk or negedge axis_streaming_rst_n) begin
    if (!axis_streaming_rst_n) begin
      state                                       <= S_IDLE;
      grant_id                                    <= GW'(N_SOURCES - 1);
      axis_streaming_data_tx_destination_ip       <= '0;
      axis_streaming_data_tx_destination_udp_port <= '0;
      axis_streaming_data_tx_source_udp_port      <= '0;
      axis_streaming_data_tx_packet_length        <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && arb_enable && found) begin
        grant_id                                    <= pick;
        axis_streaming_data_tx_destination_ip       <= src_dest_ip[int'(pick)*32 +: 32];
        axis_streaming_data_tx_destination_udp_port <= src_dest_udp_port[int'(pick)*16 +: 16];
        axis_streaming_data_tx_source_udp_port      <= src_src_udp_port[int'(pick)*16 +: 16];
        axis_streaming_data_tx_packet_length        <= src_packet_length[int'(pick)*16 +: 16];
      end
    end
  end

  // Data path is a pure mux: zero outside PASS, so an async reset clears it at once.
  always_comb begin
    axis_streaming_data_tx_tdata  = '0;
    axis_streaming_data_tx_tvalid = 1'b0;
    axis_streaming_data_tx_tkeep  = '0;
    axis_streaming_data_tx_tlast  = 1'b0;
    axis_streaming_data_tx_tuser  = 1'b0;
    src_tready                    = '0;
    if (state == S_PASS) begin
      axis_streaming_data_tx_tdata  = src_tdata[int'(grant_id)*G_AXIS_DATA_WIDTH +: G_AXIS_DATA_WIDTH];
      axis_streaming_data_tx_tvalid = src_tvalid[grant_id];
      axis_streaming_data_tx_tkeep  = src_tkeep[int'(grant_id)*G_KEEP_WIDTH +: G_KEEP_WIDTH];
      axis_streaming_data_tx_tlast  = src_tlast[grant_id];
      axis_streaming_data_tx_tuser  = src_tuser[grant_id];
      src_tready[grant_id]          = axis_streaming_data_tx_tready;
    end
  end

  assign busy = (state == S_PASS);

endmodule

// File: tb/tb_udp_tx_stream_arbiter.sv
// Directed self-checking bench for udp_tx_stream_arbiter: rotation, metadata hold, bubbles, enable, reset.
module tb_udp_tx_stream_arbiter;

  localparam int N   = 4;
  localparam int W   = 1024;
  localparam int K   = W / 8;
  localparam int LEN = 4;

`ifdef UDP_TX_ARB_STRICT_PRIO_EN
  localparam int G1 [5] = '{0, 0, 0, 0, 0};
  localparam int G4A = 0;
  localparam int G4B = 0;
`else
  localparam int G1 [5] = '{0, 1, 2, 3, 0};
  localparam int G4A = 2;
  localparam int G4B = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             arb_enable;
  logic [N*W-1:0]   src_tdata;
  logic [N-1:0]     src_tvalid;
  logic [N*K-1:0]   src_tkeep;
  logic [N-1:0]     src_tlast;
  logic [N-1:0]     src_tuser;
  logic [N-1:0]     src_tready;
  logic [N*32-1:0]  src_dest_ip;
  logic [N*16-1:0]  src_dest_udp_port;
  logic [N*16-1:0]  src_src_udp_port;
  logic [N*16-1:0]  src_packet_length;
  logic [W-1:0]     tx_tdata;
  logic             tx_tvalid;
  logic [K-1:0]     tx_tkeep;
  logic             tx_tlast;
  logic             tx_tuser;
  logic             tx_tready;
  logic [31:0]      tx_dest_ip;
  logic [15:0]      tx_dest_port;
  logic [15:0]      tx_src_port;
  logic [15:0]      tx_len;
  logic [1:0]       grant_id;
  logic             busy;

  int               checks = 0;
  int               errors = 0;
  int               cycles = 0;
  int               beat [N];
  logic [N-1:0]     en_src;
  logic [N-1:0]     bubble;

  always #5 clk = ~clk;

  udp_tx_stream_arbiter #(
    .N_SOURCES(N), .G_AXIS_DATA_WIDTH(W), .G_KEEP_WIDTH(K)
  ) dut (
    .axis_streaming_data_clk                    (clk),
    .axis_streaming_rst_n                       (rst_n),
    .arb_enable                                 (arb_enable),
    .src_tdata                                  (src_tdata),
    .src_tvalid                                 (src_tvalid),
    .src_tkeep                                  (src_tkeep),
    .src_tlast                                  (src_tlast),
    .src_tuser                                  (src_tuser),
    .src_tready                                 (src_tready),
    .src_dest_ip                                (src_dest_ip),
    .src_dest_udp_port                          (src_dest_udp_port),
    .src_src_udp_port                           (src_src_udp_port),
    .src_packet_length                          (src_packet_length),
    .axis_streaming_data_tx_tdata               (tx_tdata),
    .axis_streaming_data_tx_tvalid              (tx_tvalid),
    .axis_streaming_data_tx_tkeep               (tx_tkeep),
    .axis_streaming_data_tx_tlast               (tx_tlast),
    .axis_streaming_data_tx_tuser               (tx_tuser),
    .axis_streaming_data_tx_tready              (tx_tready),
    .axis_streaming_data_tx_destination_ip      (tx_dest_ip),
    .axis_streaming_data_tx_destination_udp_port(tx_dest_port),
    .axis_streaming_data_tx_source_udp_port     (tx_src_port),
    .axis_streaming_data_tx_packet_length       (tx_len),
    .grant_id                                   (grant_id),
    .busy                                       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each source emits beats tagged {source, beat index}; tlast/tuser mark the final beat.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_tdata[i*W +: W] = W'(i * 256 + beat[i]);
      src_tkeep[i*K +: K] = '1;
      src_tlast[i]        = (beat[i] == LEN - 1);
      src_tuser[i]        = (beat[i] == LEN - 1);
      src_tvalid[i]       = en_src[i] & ~bubble[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    #1;
    hs = src_tvalid & src_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) beat[i] = (beat[i] == LEN - 1) ? 0 : beat[i] + 1;
    drive();
    #1;
    cycles++;
    if (cycles > 5000) begin
      $display("FAIL cycle_budget: observed %0d cycles, required under 5000", cycles);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // One idle/arbitration cycle, then LEN beats from source s with tready held high.
  task automatic run_pkt(input int s, input bit drop_en);
    logic [31:0] e_ip;
    logic [15:0] e_dp, e_sp, e_len;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_tvalid", 64'(tx_tvalid), 64'd0);
    check("idle_src_tready", 64'(src_tready), 64'd0);
    e_ip  = src_dest_ip[s*32 +: 32];
    e_dp  = src_dest_udp_port[s*16 +: 16];
    e_sp  = src_src_udp_port[s*16 +: 16];
    e_len = src_packet_length[s*16 +: 16];
    step();
    for (int b = 0; b < LEN; b++) begin
      check("grant_id", 64'(grant_id), 64'(s));
      check("busy", 64'(busy), 64'd1);
      check("tx_tdata", tx_tdata[63:0], 64'(s * 256 + b));
      check("tx_tlast", 64'(tx_tlast), 64'(b == LEN - 1));
      check("tx_tuser", 64'(tx_tuser), 64'(b == LEN - 1));
      check("src_tready", 64'(src_tready), 64'(1 << s));
      check("meta_dest_ip", 64'(tx_dest_ip), 64'(e_ip));
      check("meta_dest_port", 64'(tx_dest_port), 64'(e_dp));
      check("meta_src_port", 64'(tx_src_port), 64'(e_sp));
      check("meta_length", 64'(tx_len), 64'(e_len));
      if (b == 0 && drop_en) arb_enable = 1'b0;
      if (b == 1) begin
        src_dest_ip[s*32 +: 32]       = ~e_ip;
        src_dest_udp_port[s*16 +: 16] = ~e_dp;
        src_src_udp_port[s*16 +: 16]  = ~e_sp;
        src_packet_length[s*16 +: 16] = ~e_len;
      end
      step();
    end
    src_dest_ip[s*32 +: 32]       = e_ip;
    src_dest_udp_port[s*16 +: 16] = e_dp;
    src_src_udp_port[s*16 +: 16]  = e_sp;
    src_packet_length[s*16 +: 16] = e_len;
  endtask

  initial begin
    logic [39:0] rdy_pat;
    logic [39:0] bub_pat;
    int          exp_beat;
    bit          done;

    rdy_pat    = 40'hB6_D35A_9CE1;
    bub_pat    = 40'h24_8241_0912;
    rst_n      = 1'b0;
    arb_enable = 1'b1;
    tx_tready  = 1'b1;
    en_src     = '1;
    bubble     = '0;
    for (int i = 0; i < N; i++) begin
      beat[i]                       = 0;
      src_dest_ip[i*32 +: 32]       = 32'hC0A8_0100 + 32'(i);
      src_dest_udp_port[i*16 +: 16] = 16'h1000 + 16'(i);
      src_src_udp_port[i*16 +: 16]  = 16'h2000 + 16'(i);
      src_packet_length[i*16 +: 16] = 16'h0200 + 16'(i);
    end
    drive();
    repeat (3) @(posedge clk);
    #2;

    // Reset state with all sources requesting.
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_src_tready", 64'(src_tready), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tdata", tx_tdata[63:0], 64'd0);
    check("rst_tkeep", tx_tkeep[63:0], 64'd0);
    check("rst_tlast", 64'(tx_tlast), 64'd0);
    check("rst_dest_ip", 64'(tx_dest_ip), 64'd0);
    check("rst_length", 64'(tx_len), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // All sources valid: rotation 0,1,2,3,0 with one idle cycle per packet.
    for (int p = 0; p < 5; p++) run_pkt(G1[p], 1'b0);
    check("pass_tkeep_seen", 64'(busy), 64'd0);

    // Source 2 alone, fixed metadata, two packets back to back.
    en_src = 4'b0100;
    src_dest_ip[2*32 +: 32]       = 32'hC0A8_030A;
    src_dest_udp_port[2*16 +: 16] = 16'h5678;
    src_src_udp_port[2*16 +: 16]  = 16'hABCD;
    src_packet_length[2*16 +: 16] = 16'd8192;
    drive();
    run_pkt(2, 1'b0);
    run_pkt(2, 1'b0);

    // Source 1 with bubbles and a stalling sink: every beat once, in order.
    en_src   = 4'b0010;
    exp_beat = 0;
    done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tx_tready = rdy_pat[c];
      bubble[1] = bub_pat[c];
      drive();
      #1;
      if (busy) begin
        check("bub_grant", 64'(grant_id), 64'd1);
        check("bub_tvalid_follows", 64'(tx_tvalid), 64'(src_tvalid[1]));
        check("bub_tkeep", tx_tkeep[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (tx_tvalid && tx_tready) begin
        check("bub_beat_data", tx_tdata[63:0], 64'(256 + exp_beat));
        check("bub_beat_last", 64'(tx_tlast), 64'(exp_beat == LEN - 1));
        if (tx_tlast) done = 1'b1;
        exp_beat++;
      end
      step();
    end
    check("bub_beats_total", 64'(exp_beat), 64'(LEN));
    check("bub_done_idle", 64'(busy), 64'd0);
    tx_tready = 1'b1;
    bubble    = '0;
    en_src    = '1;
    drive();

    // Enable dropped in beat 0: packet completes, no new grant until re-enabled.
    run_pkt(G4A, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check("dis_busy", 64'(busy), 64'd0);
      check("dis_tvalid", 64'(tx_tvalid), 64'd0);
      check("dis_grant_held", 64'(grant_id), 64'(G4A));
      step();
    end
    arb_enable = 1'b1;
    run_pkt(G4B, 1'b0);

    // Async reset mid-packet: outputs clear in the same cycle, then source 0 wins.
    step();
    check("pre_rst_grant", 64'(grant_id), 64'd0);
    step();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(tx_tvalid), 64'd0);
    check("arst_src_tready", 64'(src_tready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_grant_id", 64'(grant_id), 64'd3);
    check("arst_dest_ip", 64'(tx_dest_ip), 64'd0);
    for (int i = 0; i < N; i++) beat[i] = 0;
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    run_pkt(0, 1'b0);

    // Source 0 silent: remaining sources rotate 1,2,3 in either arbitration mode.
    en_src = 4'b1110;
    drive();
    run_pkt(1, 1'b0);
    run_pkt(2, 1'b0);
    run_pkt(3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_stream_arbiter.md
Name: udp_tx_stream_arbiter

Overview:
- Packet-level arbiter that shares the single 1024-bit AXIS streaming TX port of the 400G UDP/IP interface between N_SOURCES independent generators.
- Each source presents its own AXIS stream plus per-packet metadata: destination IP, destination UDP port, source UDP port and packet length.
- The block grants one source per packet, round-robin, and muxes that source's data and latched metadata onto the interface TX port.
- Sits between the data generators and the axis_streaming_data_tx_* port of the UDP/IP interface, in the streaming clock domain.

Parameters:
- N_SOURCES, 4, number of requesters (2..8).
- G_AXIS_DATA_WIDTH, 1024, tdata width in bits.
- G_KEEP_WIDTH, G_AXIS_DATA_WIDTH/8, tkeep width.

Ports:
- axis_streaming_data_clk  in  1  streaming clock; all logic on the rising edge.
- axis_streaming_rst_n  in  1  asynchronous, active-low reset.
- arb_enable  in  1  when low, no new grants are issued.
- src_tdata  in  N*G_AXIS_DATA_WIDTH  per-source data, source i at slice i.
- src_tvalid  in  N  per-source valid.
- src_tkeep  in  N*G_KEEP_WIDTH  per-source keep.
- src_tlast  in  N  per-source last.
- src_tuser  in  N  per-source user.
- src_tready  out  N  per-source ready.
- src_dest_ip  in  N*32  per-source destination IP.
- src_dest_udp_port  in  N*16  per-source destination UDP port.
- src_src_udp_port  in  N*16  per-source source UDP port.
- src_packet_length  in  N*16  per-source packet length in bytes.
- axis_streaming_data_tx_tdata  out  G_AXIS_DATA_WIDTH  muxed data.
- axis_streaming_data_tx_tvalid  out  1  muxed valid.
- axis_streaming_data_tx_tkeep  out  G_KEEP_WIDTH  muxed keep.
- axis_streaming_data_tx_tlast  out  1  muxed last.
- axis_streaming_data_tx_tuser  out  1  muxed user.
- axis_streaming_data_tx_tready  in  1  downstream ready.
- axis_streaming_data_tx_destination_ip  out  32  latched metadata.
- axis_streaming_data_tx_destination_udp_port  out  16  latched metadata.
- axis_streaming_data_tx_source_udp_port  out  16  latched metadata.
- axis_streaming_data_tx_packet_length  out  16  latched metadata.
- grant_id  out  clog2(N)  index of the currently or last granted source.
- busy  out  1  high while in PASS.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all src_tready=0, tx_tvalid=0, tx_tlast=0, tx_tuser=0.
  - tx_tdata/tkeep=0; all metadata outputs=0.
  - grant_id=N-1, so the first round-robin pick is source 0; busy=0.
- States: IDLE, PASS.
- IDLE:
  - If arb_enable=1 and any src_tvalid=1, pick the first requesting index scanning last_grant+1 .. last_grant+N, modulo N.
  - Register grant_id; latch that source's four metadata fields into the output registers; go to PASS.
  - Arbitration costs exactly one cycle. No data passes in IDLE; all src_tready=0.
- PASS:
  - Combinational mux: tx_tdata/tvalid/tkeep/tlast/tuser = src[grant_id].
  - src_tready[grant_id] = tx_tready; every other src_tready=0.
  - Metadata outputs are held constant for the whole packet, even if the source's metadata inputs change.
  - On tx_tvalid & tx_tready & tx_tlast, return to IDLE; grant_id keeps its value as the round-robin pointer.
- Back-to-back packets: minimum one idle cycle between packets, from any source.
- Grants are never revoked mid-packet. arb_enable falling during PASS lets the current packet complete; no further grants are issued.
- The granted source may deassert tvalid mid-packet (bubbles). The grant holds and tx_tvalid follows the source.
- A source whose tvalid drops while waiting in IDLE is simply not picked; no stale request is kept.
- Single requester: re-granted every packet, with one gap cycle each.
- Async reset during PASS: outputs clear immediately; the partial packet is abandoned, and downstream framing recovery is the interface's responsibility.
- No width arithmetic beyond the modulo-N pointer wrap; N not a power of 2 must wrap correctly, e.g. N=3 goes 2 -> 0.

Optional Feature:
- Macro: UDP_TX_ARB_STRICT_PRIO_EN.
- When defined: in IDLE, source 0 wins whenever src_tvalid[0]=1. Otherwise round-robin applies over sources 1..N-1, using the same pointer.
- When undefined: pure round-robin over all N sources, exactly as above. No extra ports in either case.

Test Plan:
- All 4 sources continuously valid, 64-beat packets (8192 B), tx_tready=1 -> grants in order 0,1,2,3,0,...; metadata changes only on the cycle after tx_tlast; 1 idle cycle between packets.
- Source 2 only, dest_ip 0xC0A8030A, ports 0x5678/0xABCD, length 8192 -> four consecutive packets from source 2; metadata outputs equal these values throughout; src_tready[0,1,3]=0 always.
- Random tx_tready (50%) plus source bubbles -> every beat appears on the output exactly once, in order; the grant never changes before tlast; no beats are lost or duplicated.
- arb_enable dropped at beat 10 of a 64-beat packet -> the packet completes on beat 64; busy=0 afterwards; no new grant while enable=0; the next grant after re-enable is the next round-robin index.
- axis_streaming_rst_n pulsed low mid-packet -> tx_tvalid=0 and all src_tready=0 in the same cycle; after release the first grant goes to source 0.
- With UDP_TX_ARB_STRICT_PRIO_EN and all sources valid -> source 0 is granted every packet; sources 1..3 are granted only while src_tvalid[0]=0, in rotating order.
